// File: rtl/seg_display_scheduler_if.sv
// Game-side bundle for the score/display scheduler: score inputs from game logic
// and the digit-scan outputs toward the segment decoder and anode pins.
interface seg_display_scheduler_if;
    logic        score_signal;
    logic [3:0]  get_score;
    logic        game_end;
    logic        clr_score;
    logic [3:0]  selected;
    logic [3:0]  digit_val;
    logic        blank;
    logic [15:0] score_bcd;

    modport master (
        output score_signal, get_score, game_end, clr_score,
        input  selected, digit_val, blank, score_bcd
    );

    modport slave (
        input  score_signal, get_score, game_end, clr_score,
        output selected, digit_val, blank, score_bcd
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Owns the 4-digit BCD score and time-multiplexes it onto a shared seven-segment
// decoder with leading-zero blanking and a game-over blink.
module seg_display_scheduler #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 256
) (
    input logic                    clk,
    input logic                    rst,
    seg_display_scheduler_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic          s1_r, s2_r, s3_r;
    logic          event_s;
    logic [15:0]   score_r;
    logic [SW-1:0] scan_cnt_r;
    logic          tick_s;
    logic [1:0]    idx_r;
    logic [BW-1:0] blink_cnt_r;
    logic          phase_on_r;
    logic          phase_on_s;
    logic [3:0]    sel_r, val_r;
    logic          blank_r;
    logic [3:0]    sel_nx_s, val_nx_s, en_s, nib_s;
    logic          blank_nx_s, suppress_s;

    // Decimal add with per-digit carry; points above 9 saturate to 9, result wraps mod 10000.
    function automatic logic [15:0] bcd_add(input logic [15:0] acc, input logic [3:0] pts);
        logic [15:0] sum;
        logic [4:0]  dig;
        logic [3:0]  p;
        logic        carry;
        p     = (pts > 4'd9) ? 4'd9 : pts;
        carry = 1'b0;
        sum   = 16'd0;
        for (int i = 0; i < 4; i++) begin
            dig = {1'b0, acc[4*i +: 4]} + {1'b0, ((i == 0) ? p : 4'd0)} + {4'd0, carry};
            if (dig > 5'd9) begin
                dig   = dig - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = dig[3:0];
        end
        return sum;
    endfunction

    assign event_s    = s2_r & ~s3_r;
    assign tick_s     = (scan_cnt_r == SCAN_LAST);
    // Once game_end drops the display is forced back on even if the phase flop lags a cycle.
    assign phase_on_s = ~bus.game_end | phase_on_r;

    // Score-event synchronizer and score accumulator (clear > freeze > add).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            s3_r    <= 1'b0;
            score_r <= 16'd0;
        end else begin
            s1_r <= bus.score_signal;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (bus.clr_score) begin
                score_r <= 16'd0;
            end else if (bus.game_end) begin
                score_r <= score_r;
            end else if (event_s) begin
                score_r <= bcd_add(score_r, bus.get_score);
            end else begin
                score_r <= score_r;
            end
        end
    end

    // Select the nibble and anode pattern for the slot about to be shown.
    always_comb begin
        en_s       = 4'b1111;
        nib_s      = 4'd0;
        suppress_s = 1'b0;
        sel_nx_s   = 4'b1111;
        val_nx_s   = 4'd0;
        blank_nx_s = 1'b1;
        case (idx_r)
            2'd0: begin en_s = 4'b0111; nib_s = score_r[3:0];   suppress_s = 1'b0; end
            2'd1: begin en_s = 4'b1011; nib_s = score_r[7:4];   suppress_s = (score_r[15:4]  == 12'd0); end
            2'd2: begin en_s = 4'b1101; nib_s = score_r[11:8];  suppress_s = (score_r[15:8]  == 8'd0);  end
            2'd3: begin en_s = 4'b1110; nib_s = score_r[15:12]; suppress_s = (score_r[15:12] == 4'd0);  end
            default: begin en_s = 4'b1111; nib_s = 4'd0; suppress_s = 1'b1; end
        endcase
        if (suppress_s || !phase_on_s) begin
            sel_nx_s   = 4'b1111;
            val_nx_s   = 4'd0;
            blank_nx_s = 1'b1;
        end else begin
            sel_nx_s   = en_s;
            val_nx_s   = nib_s;
            blank_nx_s = 1'b0;
        end
    end

    // Scan divider, digit rotation, registered display outputs and blink phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r  <= '0;
            idx_r       <= 2'd0;
            sel_r       <= 4'b1111;
            val_r       <= 4'd0;
            blank_r     <= 1'b1;
            blink_cnt_r <= '0;
            phase_on_r  <= 1'b1;
        end else begin
            if (tick_s) begin
                scan_cnt_r <= '0;
                idx_r      <= idx_r + 2'd1;
                sel_r      <= sel_nx_s;
                val_r      <= val_nx_s;
                blank_r    <= blank_nx_s;
            end else begin
                scan_cnt_r <= scan_cnt_r + SW'(1);
            end
            if (!bus.game_end) begin
                blink_cnt_r <= '0;
                phase_on_r  <= 1'b1;
            end else if (tick_s) begin
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r <= '0;
                    phase_on_r  <= ~phase_on_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BW'(1);
                end
            end else begin
                blink_cnt_r <= blink_cnt_r;
            end
        end
    end

    assign bus.selected  = sel_r;
    assign bus.digit_val = val_r;
    assign bus.blank     = blank_r;
    assign bus.score_bcd = score_r;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with SCAN_DIV = 4 and BLINK_TICKS = 2.
module tb_seg_display_scheduler;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    seg_display_scheduler_if bus ();

    seg_display_scheduler #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    // Ticks fall on edges 4,8,12,...; tick t shows digit index (t-1)%4.
    task automatic goto_idx(input int k);
        for (int i = 0; i < 32; i++) begin
            step(1);
            if ((cyc % 4 == 0) && (cyc >= 4) && (((cyc / 4) - 1) % 4 == k)) break;
        end
    endtask

    task automatic pulse(input logic [3:0] pts);
        bus.get_score    = pts;
        bus.score_signal = 1'b1;
        step(1);
        bus.score_signal = 1'b0;
        step(3);
    endtask

    task automatic check_disp(input string tag, input logic [3:0] sel, input logic [3:0] val, input logic blk);
        check_val({tag, ".sel"},   16'(bus.selected),  16'(sel));
        check_val({tag, ".val"},   16'(bus.digit_val), 16'(val));
        check_val({tag, ".blank"}, 16'(bus.blank),     16'(blk));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b0;
        bus.score_signal = 1'b0;
        bus.get_score    = 4'd0;
        bus.game_end     = 1'b0;
        bus.clr_score    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_disp("reset", 4'b1111, 4'd0, 1'b1);
        check_val("reset.score", bus.score_bcd, 16'h0000);
        rst = 1'b1;
        cyc = 0;

        // Scan after reset: nothing shown until the first tick, then only the ones digit.
        step(3);
        check_disp("pre_tick", 4'b1111, 4'd0, 1'b1);
        step(1);
        check_disp("tick1_ones", 4'b0111, 4'd0, 1'b0);
        step(4);
        check_disp("tick2_tens", 4'b1111, 4'd0, 1'b1);
        step(4);
        check_disp("tick3_hund", 4'b1111, 4'd0, 1'b1);
        step(4);
        check_disp("tick4_thou", 4'b1111, 4'd0, 1'b1);
        step(4);
        check_disp("tick5_ones", 4'b0111, 4'd0, 1'b0);

        // First event with explicit latency: update lands two edges after first sample.
        bus.get_score    = 4'd7;
        bus.score_signal = 1'b1;
        step(1);
        bus.score_signal = 1'b0;
        check_val("lat_n", bus.score_bcd, 16'h0000);
        step(1);
        check_val("lat_n1", bus.score_bcd, 16'h0000);
        step(1);
        check_val("lat_n2", bus.score_bcd, 16'h0007);
        step(1);
        pulse(4'd7);
        pulse(4'd7);
        check_val("score21", bus.score_bcd, 16'h0021);
        goto_idx(0);
        check_disp("s21_ones", 4'b0111, 4'd1, 1'b0);
        goto_idx(1);
        check_disp("s21_tens", 4'b1011, 4'd2, 1'b0);
        goto_idx(2);
        check_disp("s21_hund", 4'b1111, 4'd0, 1'b1);
        goto_idx(3);
        check_disp("s21_thou", 4'b1111, 4'd0, 1'b1);

        // Clear, preload 9998, then wrap and clamp.
        bus.clr_score = 1'b1;
        step(1);
        bus.clr_score = 1'b0;
        check_val("clr", bus.score_bcd, 16'h0000);
        for (int i = 0; i < 1110; i++) pulse(4'd9);
        pulse(4'd8);
        check_val("pre9998", bus.score_bcd, 16'h9998);
        pulse(4'd5);
        check_val("wrap", bus.score_bcd, 16'h0003);
        pulse(4'hC);
        check_val("clamp", bus.score_bcd, 16'h0012);
        pulse(4'd0);
        check_val("add0", bus.score_bcd, 16'h0012);

        // A held level is one event.
        bus.get_score    = 4'd1;
        bus.score_signal = 1'b1;
        step(1000);
        bus.score_signal = 1'b0;
        step(3);
        check_val("held", bus.score_bcd, 16'h0013);

        // Event and clear in the same cycle: clear wins.
        bus.get_score    = 4'd5;
        bus.score_signal = 1'b1;
        step(2);
        bus.clr_score = 1'b1;
        step(1);
        bus.clr_score    = 1'b0;
        bus.score_signal = 1'b0;
        check_val("clr_vs_evt", bus.score_bcd, 16'h0000);
        step(3);
        check_val("clr_vs_evt2", bus.score_bcd, 16'h0000);

        // Game end: freeze and blink with score 42.
        for (int i = 0; i < 4; i++) pulse(4'd9);
        pulse(4'd6);
        check_val("score42", bus.score_bcd, 16'h0042);
        goto_idx(0);
        bus.game_end = 1'b1;
        step(4);
        check_disp("ge_t1", 4'b1011, 4'd4, 1'b0);
        pulse(4'd3);
        check_disp("ge_t2", 4'b1111, 4'd0, 1'b1);
        check_val("ge_frozen", bus.score_bcd, 16'h0042);
        step(4);
        check_disp("ge_t3", 4'b1111, 4'd0, 1'b1);
        step(4);
        check_disp("ge_t4_off", 4'b1111, 4'd0, 1'b1);
        step(4);
        check_disp("ge_t5_on", 4'b1011, 4'd4, 1'b0);
        step(4);
        step(4);
        bus.game_end = 1'b0;
        step(4);
        check_disp("ge_resume", 4'b0111, 4'd2, 1'b0);

        // Build 1234, check all digits, then reset mid-slot.
        bus.clr_score = 1'b1;
        step(1);
        bus.clr_score = 1'b0;
        for (int i = 0; i < 137; i++) pulse(4'd9);
        pulse(4'd1);
        check_val("score1234", bus.score_bcd, 16'h1234);
        goto_idx(0);
        check_disp("s1234_ones", 4'b0111, 4'd4, 1'b0);
        goto_idx(1);
        check_disp("s1234_tens", 4'b1011, 4'd3, 1'b0);
        goto_idx(2);
        check_disp("s1234_hund", 4'b1101, 4'd2, 1'b0);
        goto_idx(3);
        check_disp("s1234_thou", 4'b1110, 4'd1, 1'b0);
        step(1);
        #2;
        rst = 1'b0;
        #1;
        check_disp("async_rst", 4'b1111, 4'd0, 1'b1);
        check_val("async_rst.score", bus.score_bcd, 16'h0000);
        #2;
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
Controller that owns the 4-digit BCD score and sequences the shared 4-digit seven-segment display.
- Accumulates points on synchronized score events.
- Time-multiplexes one digit at a time onto the shared segment decoder.
- Blanks leading zeros.
- Blinks the whole display after game end.
- Sits between game logic and the segment decoder and anode pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit scan slot (>=2)
BLINK_TICKS, 256, scan ticks per blink half-period during game end (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
score_signal  in  1  asynchronous level from game logic; each rising edge is one score event
get_score  in  4  points per event, BCD 0-9; values 10-15 are clamped to 9
game_end  in  1  level; high freezes the score and blinks the display
clr_score  in  1  synchronous score clear, single-cycle pulse
selected  out  4  active-low digit enables: 0111 = ones, 1011 = tens, 1101 = hundreds, 1110 = thousands, 1111 = none
digit_val  out  4  BCD nibble to the decoder for the active digit
blank  out  1  1 = decoder must drive all segments off
score_bcd  out  16  {thousands, hundreds, tens, ones}

Behaviour:
- Reset (rst = 0, asynchronous):
  - score_bcd = 0, selected = 4'b1111, digit_val = 0, blank = 1.
  - Scan counter = 0, digit index = 0, blink phase = on, synchronizer flops = 0.
  - Reset asserted mid-scan or mid-add aborts immediately; no partial update survives.
- Event detect:
  - score_signal passes through 2 flops (s1, s2), plus a history flop s3.
  - event = s2 & ~s3.
  - A rising edge first sampled at clk edge N updates score_bcd at edge N+2.
  - A level held high produces exactly one event.
- Score update priority, per cycle: clr_score, then game_end, then event.
  - clr_score: score_bcd <= 0.
  - game_end high: events are discarded, and score_bcd is held (clr_score still clears).
  - Otherwise, on event: BCD add of the clamped get_score.
    - Per-digit decimal carry; no nibble ever holds a value >9.
    - 9999 wraps modulo 10000, e.g. 9998 + 5 = 0003.
    - get_score = 0 leaves the score unchanged.
- Scan scheduler:
  - Free-running counter 0..SCAN_DIV-1.
  - tick = 1 in the cycle the counter equals SCAN_DIV-1.
  - On each tick, the digit index advances 0→1→2→3→0. selected, digit_val and blank are registered on that same edge for the new index.
  - The first tick after reset displays index 0 (ones).
- Per-digit output for index k:
  - digit_val = score nibble k, sampled at the tick edge.
  - Leading-zero suppression: for k >= 1, the digit is suppressed when nibble k and all higher nibbles are 0. Index 0 is never suppressed.
  - Suppressed digit or blink-off phase: selected = 4'b1111, blank = 1, digit_val = 0.
  - Otherwise: selected = the enable pattern for k, blank = 0.
- Blink:
  - While game_end = 1, a counter counts ticks; the phase toggles every BLINK_TICKS ticks, starting in the on phase.
  - Rising game_end resets the counter and sets the phase to on.
  - When game_end falls, normal display resumes at the next tick with phase = on.
- Score changes between ticks take effect at the next tick; the displayed digit is never altered within a slot.

Test Plan:
- Reset, then release with SCAN_DIV = 4 → selected = 1111, blank = 1; first tick at cycle 4 gives selected = 0111, digit_val = 0, blank = 0; ticks at 8/12/16 give 1111 (zeros suppressed), then ones again.
- get_score = 7, three score_signal pulses → score_bcd = 0x0021. Each update lands 2 edges after first sample. Scan shows ones = 1 (0111), tens = 2 (1011), hundreds and thousands suppressed.
- Preload to 9998 via events, then get_score = 5 → score_bcd = 0x0003. Also get_score = 4'hC → adds 9.
- score_signal held high for 1000 cycles → exactly one increment. Event and clr_score in the same cycle → score_bcd = 0.
- game_end = 1 with BLINK_TICKS = 2 and score 0x0042 → events ignored. Ticks 1-2 show digits normally, ticks 3-4 give selected = 1111, blank = 1, repeating. game_end = 0 → normal scan at the next tick.
- rst driven low mid-slot with score 0x1234 → outputs immediately return to reset values without waiting for a clock.
